// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// Fetch-side branch predictor (direct-mapped BTB with per-entry saturating
// counters) paired with an execute-side resolver. The resolver evaluates the
// real taken/target outcome of the EX instruction, compares it with the
// prediction carried down the pipe, trains the tables and issues a
// registered one-cycle redirect to fetch on a mispredict.
//
// Parameters:
//   XLEN        datapath / PC width (PCs are word addresses)
//   BHT_ENTRIES table depth, power of 2, >= 2
//   CTR_BITS    saturating counter width, 2..4
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   fetch_pc          PC being looked up by fetch
//   pred_taken        combinational prediction for fetch_pc
//   pred_target       predicted next PC (fetch_pc+1 when not taken)
//   ex_valid          EX instruction valid
//   ex_pc             PC of the EX instruction
//   branch/jal/jalr   control-flow decode of the EX instruction
//   funct3, zero      branch condition select and ALU zero flag
//   imm               signed byte offset (shifted to words internally)
//   arith             ALU result, used as the jalr target
//   ex_pred_taken     prediction that travelled with the EX instruction
//   ex_pred_target    predicted target that travelled with it
//   redirect_valid    registered one-cycle mispredict pulse
//   redirect_pc       correct next PC, held between redirects
//
// Optional feature, macro BPU_STATS_EN:
//   adds stat_branches / stat_mispredicts, 32-bit saturating event counters.
// ---------------------------------------------------------------------------
module branch_predict_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CTR_BITS    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            branch,
    input  logic            jal,
    input  logic            jalr,
    input  logic [2:0]      funct3,
    input  logic            zero,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] arith,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX  = $clog2(BHT_ENTRIES);
    localparam int TAGW = XLEN - IDX;

    // Reset value is weakly not-taken; a fresh allocation starts weakly taken.
    localparam logic [CTR_BITS-1:0] CTR_RST = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_WT  = {1'b1, {(CTR_BITS-1){1'b0}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_MIN = {CTR_BITS{1'b0}};
    localparam logic [CTR_BITS-1:0] CTR_ONE = {{(CTR_BITS-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]     PC_ONE  = {{(XLEN-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Table storage
    // ------------------------------------------------------------------
    logic [BHT_ENTRIES-1:0] valid_q;
    logic [BHT_ENTRIES-1:0] is_jump_q;
    logic [CTR_BITS-1:0]    ctr_q    [BHT_ENTRIES];
    logic [TAGW-1:0]        tag_q    [BHT_ENTRIES];
    logic [XLEN-1:0]        target_q [BHT_ENTRIES];

    // ------------------------------------------------------------------
    // Fetch-side lookup (reads current contents, so a same-cycle update
    // to the same index is only visible from the next cycle)
    // ------------------------------------------------------------------
    logic [IDX-1:0] f_idx;
    logic           f_hit;

    assign f_idx = fetch_pc[IDX-1:0];
    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == fetch_pc[XLEN-1:IDX]);

    assign pred_taken  = f_hit && (is_jump_q[f_idx] || ctr_q[f_idx][CTR_BITS-1]);
    assign pred_target = pred_taken ? target_q[f_idx] : fetch_pc + PC_ONE;

    // ------------------------------------------------------------------
    // Execute-side resolve
    // ------------------------------------------------------------------
    logic [IDX-1:0]      e_idx;
    logic                e_hit;
    logic                taken;
    logic [XLEN-1:0]     imm_words;
    logic [XLEN-1:0]     target;
    logic [XLEN-1:0]     correct_pc;
    logic                mispredict;
    logic                upd_hit;
    logic                alloc;
    logic                alias_clr;
    logic [CTR_BITS-1:0] ctr_nxt;

    assign e_idx = ex_pc[IDX-1:0];
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == ex_pc[XLEN-1:IDX]);

    // Byte offset converted to a word offset, keeping its sign.
    assign imm_words = $unsigned($signed(imm) >>> 2);

    assign taken      = branch && (jal || jalr || ((|funct3) ^ zero));
    assign target     = jalr ? arith : imm_words + ex_pc;
    assign correct_pc = taken ? target : ex_pc + PC_ONE;
    assign mispredict = ex_valid &&
                        ((taken != ex_pred_taken) || (taken && (target != ex_pred_target)));

    assign upd_hit   = ex_valid &&  branch &&  e_hit;
    assign alloc     = ex_valid &&  branch && !e_hit && taken;
    // A non-control-flow instruction that hits was aliased into the table.
    assign alias_clr = ex_valid && !branch &&  e_hit;

    // NOTE: every always_comb output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        ctr_nxt = ctr_q[e_idx];
        if (taken) begin
            if (ctr_q[e_idx] != CTR_MAX) ctr_nxt = ctr_q[e_idx] + CTR_ONE;
        end else begin
            if (ctr_q[e_idx] != CTR_MIN) ctr_nxt = ctr_q[e_idx] - CTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Control state: valid bits, counters, redirect
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values, independent of statement order within the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q        <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) ctr_q[i] <= CTR_RST;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict) redirect_pc <= correct_pc;

            if (upd_hit) begin
                ctr_q[e_idx] <= ctr_nxt;
            end else if (alloc) begin
                valid_q[e_idx] <= 1'b1;
                ctr_q[e_idx]   <= CTR_WT;
            end else if (alias_clr) begin
                valid_q[e_idx] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Payload: tag, target, is_jump
    // ------------------------------------------------------------------
    // NOTE: payload fields are qualified by valid_q, so they carry no reset;
    // this keeps them plain RAM-style storage.
    always_ff @(posedge clk) begin
        if (alloc) begin
            tag_q[e_idx]     <= ex_pc[XLEN-1:IDX];
            target_q[e_idx]  <= target;
            is_jump_q[e_idx] <= jal || jalr;
        end else if (upd_hit && taken) begin
            target_q[e_idx]  <= target;
        end
    end

`ifdef BPU_STATS_EN
    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (ex_valid && branch && !(&stat_branches))
                stat_branches <= stat_branches + 32'd1;
            if (mispredict && !(&stat_mispredicts))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
//
// Directed bench for branch_predict_unit. Each EX step pushes its expected
// redirect (valid, pc) into a scoreboard queue; after the clock edge the
// entry is popped and compared with the DUT outputs. Lookups are checked
// combinationally between edges. Stat counters are checked when
// BPU_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic [2:0]  funct3;
    logic        zero;
    logic [31:0] imm;
    logic [31:0] arith;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BPU_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int   tests = 0;
    int   fails = 0;
    int   exp_br = 0;
    int   exp_mp = 0;
    exp_t sb[$];

    branch_predict_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .branch         (branch),
        .jal            (jal),
        .jalr           (jalr),
        .funct3         (funct3),
        .zero           (zero),
        .imm            (imm),
        .arith          (arith),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef BPU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic exp_t_k,
                        input logic [31:0] exp_tgt, input string name);
        fetch_pc = pc;
        #1;
        check({name, ".pred_taken"},  {31'd0, pred_taken}, {31'd0, exp_t_k});
        check({name, ".pred_target"}, pred_target, exp_tgt);
    endtask

    task automatic ex_drive(input logic v, input logic br, input logic j, input logic jr,
                            input logic [2:0] f3, input logic z, input logic [31:0] im,
                            input logic [31:0] ar, input logic [31:0] pc,
                            input logic ptk, input logic [31:0] ptgt,
                            input logic exp_v, input logic [31:0] exp_pc,
                            input string name);
        exp_t e;
        ex_valid = v;  branch = br; jal = j; jalr = jr;
        funct3 = f3;   zero = z;    imm = im; arith = ar;
        ex_pc = pc;    ex_pred_taken = ptk; ex_pred_target = ptgt;
        e.v = exp_v; e.pc = exp_pc; e.name = name;
        sb.push_back(e);
        if (v && br) exp_br++;
        if (exp_v)   exp_mp++;
    endtask

    task automatic ex_commit();
        exp_t e;
        @(posedge clk);
        #1;
        ex_valid = 1'b0; branch = 1'b0; jal = 1'b0; jalr = 1'b0;
        ex_pred_taken = 1'b0;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard: observed empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            check({e.name, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, e.v});
            check({e.name, ".redirect_pc"},    redirect_pc, e.pc);
        end
    endtask

    task automatic ex_step(input logic br, input logic j, input logic jr,
                           input logic [2:0] f3, input logic z, input logic [31:0] im,
                           input logic [31:0] ar, input logic [31:0] pc,
                           input logic ptk, input logic [31:0] ptgt,
                           input logic exp_v, input logic [31:0] exp_pc,
                           input string name);
        ex_drive(1'b1, br, j, jr, f3, z, im, ar, pc, ptk, ptgt, exp_v, exp_pc, name);
        ex_commit();
    endtask

    initial begin
        rst_n = 1'b0; fetch_pc = 32'h40;
        ex_valid = 1'b0; ex_pc = '0; branch = 1'b0; jal = 1'b0; jalr = 1'b0;
        funct3 = '0; zero = 1'b0; imm = '0; arith = '0;
        ex_pred_taken = 1'b0; ex_pred_target = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        look(32'h40, 1'b0, 32'h41, "reset");
        check("reset.redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("reset.redirect_pc", redirect_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // beq taken, predicted not-taken: allocate and redirect to 0x18
        ex_step(1, 0, 0, 3'd0, 1, 32'h20, 32'h0, 32'h10, 0, 32'h0, 1, 32'h18, "beq_alloc");
        ex_step(0, 0, 0, 3'd0, 0, 32'h0, 32'h0, 32'h100, 0, 32'h0, 0, 32'h18, "pulse_once");
        look(32'h10, 1'b1, 32'h18, "beq_pred");

        // bne not-taken, predicted taken: counter 10 -> 01
        ex_step(1, 0, 0, 3'd1, 1, 32'h20, 32'h0, 32'h10, 1, 32'h18, 1, 32'h11, "bne_nt");
        look(32'h10, 1'b0, 32'h11, "bne_pred");

        // ex_valid=0: would be a taken mispredict, must not redirect or train
        ex_drive(0, 1, 0, 0, 3'd0, 1, 32'h20, 32'h0, 32'h10, 0, 32'h0, 0, 32'h11, "exv0");
        ex_commit();
        look(32'h10, 1'b0, 32'h11, "exv0_pred");

        // jalr at 0x30 (same index as 0x10, different tag): evicts 0x10
        ex_step(1, 0, 1, 3'd0, 0, 32'h0, 32'h200, 32'h30, 1, 32'h18, 1, 32'h200, "jalr");
        look(32'h30, 1'b1, 32'h200, "jalr_pred");
        look(32'h10, 1'b0, 32'h11, "evicted");

        // Non-branch hitting the entry: alias clears valid
        ex_step(0, 0, 0, 3'd0, 0, 32'h0, 32'h0, 32'h30, 1, 32'h200, 1, 32'h31, "alias");
        look(32'h30, 1'b0, 32'h31, "alias_pred");

        // Train 0x10 up to saturation, then back down
        ex_step(1, 0, 0, 3'd0, 1, 32'h20, 32'h0, 32'h10, 0, 32'h0, 1, 32'h18, "t5a");
        ex_step(1, 0, 0, 3'd0, 1, 32'h20, 32'h0, 32'h10, 1, 32'h18, 0, 32'h18, "t5b");
        ex_step(1, 0, 0, 3'd0, 1, 32'h20, 32'h0, 32'h10, 1, 32'h18, 0, 32'h18, "t5c");
        ex_step(1, 0, 0, 3'd0, 1, 32'h20, 32'h0, 32'h10, 1, 32'h18, 0, 32'h18, "t5d");
        ex_step(1, 0, 0, 3'd0, 0, 32'h20, 32'h0, 32'h10, 1, 32'h18, 1, 32'h11, "t5e");
        look(32'h10, 1'b1, 32'h18, "t5e_pred");
        // Counter 10 -> 01 with a same-cycle lookup seeing the old value
        ex_drive(1, 1, 0, 0, 3'd0, 0, 32'h20, 32'h0, 32'h10, 1, 32'h18, 1, 32'h11, "t5f");
        look(32'h10, 1'b1, 32'h18, "same_cycle_old");
        ex_commit();
        look(32'h10, 1'b0, 32'h11, "same_cycle_new");

        // jal with negative offset wrapping below zero: 2 + (-16>>>2) = -2
        ex_step(1, 1, 0, 3'd0, 0, 32'hFFFF_FFF0, 32'h0, 32'h2, 0, 32'h0, 1, 32'hFFFF_FFFE, "jal_wrap");
        look(32'h2, 1'b1, 32'hFFFF_FFFE, "jal_pred");
        // Correct direction, wrong target still mispredicts
        ex_step(1, 1, 0, 3'd0, 0, 32'hFFFF_FFF0, 32'h0, 32'h2, 1, 32'h100, 1, 32'hFFFF_FFFE, "bad_target");

        // Reset while a redirect is being presented
        ex_step(1, 0, 0, 3'd0, 1, 32'h20, 32'h0, 32'h10, 0, 32'h0, 1, 32'h18, "pre_reset");
`ifdef BPU_STATS_EN
        check("stat_branches", stat_branches, 32'(exp_br));
        check("stat_mispredicts", stat_mispredicts, 32'(exp_mp));
`endif
        rst_n = 1'b0;
        #1;
        check("rst.redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst.redirect_pc", redirect_pc, 32'd0);
        look(32'h10, 1'b0, 32'h11, "rst_pred_10");
        look(32'h2, 1'b0, 32'h3, "rst_pred_2");
`ifdef BPU_STATS_EN
        check("rst.stat_branches", stat_branches, 32'd0);
        check("rst.stat_mispredicts", stat_mispredicts, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset.redirect_valid", {31'd0, redirect_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
